// File: rtl/unsat_clause_scan_scheduler.sv
// unsat_clause_scan_scheduler: picks one unsatisfied clause by scanning a snapshot from an LFSR-chosen start, one clause per cycle.
module unsat_clause_scan_scheduler #(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 4,
    parameter int NUMBER_OF_CLAUSES = 16,
    parameter int LFSR_WIDTH = 16
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset,
    input  logic                                          in_start,
    input  logic [NUMBER_OF_CLAUSES-1:0]                  in_clauses_satisfied,
    input  logic                                          in_seed_load,
    input  logic [LFSR_WIDTH-1:0]                         in_seed,
    output logic                                          out_busy,
    output logic                                          out_done,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic                                          out_clause_satisfied
);
    localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N = NUMBER_OF_CLAUSES;
    localparam int LW = LFSR_WIDTH;
    localparam logic [W:0] N_EXT = (W + 1)'(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [LW-1:0] LFSR_INIT = LW'(16'hACE1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lfsr_q, lfsr_d;
    logic [N-1:0]  snap_q, snap_d;
    logic [W-1:0]  ptr_q, ptr_d, cnt_q, cnt_d, idx_q, idx_d;
    logic          busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic          fb;
    logic [W:0]    r_ext;
    logic [W-1:0]  start_idx;

    // Taps 16,14,13,11 of the x^16+x^14+x^13+x^11+1 polynomial
    assign fb = lfsr_q[LW-1] ^ lfsr_q[LW-3] ^ lfsr_q[LW-4] ^ lfsr_q[LW-6];
    // N > 2^(W-1) guarantees one conditional subtract reduces r into [0, N-1]
    assign r_ext = {1'b0, lfsr_q[W-1:0]};
    assign start_idx = (r_ext < N_EXT) ? lfsr_q[W-1:0] : W'(r_ext - N_EXT);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        snap_d  = snap_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    snap_d  = in_clauses_satisfied;
                    ptr_d   = start_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = SCAN;
                    lfsr_d  = {lfsr_q[LW-2:0], fb};
                end
                // A seed load wins over the advance of a coincident start
                if (in_seed_load) lfsr_d = (in_seed == '0) ? LW'(1) : in_seed;
            end
            SCAN: begin
                if (!snap_q[ptr_q] || cnt_q == LAST) begin
                    idx_d   = snap_q[ptr_q] ? '0 : ptr_q;
                    sat_d   = snap_q[ptr_q];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            snap_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            snap_q  <= snap_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign out_busy             = busy_q;
    assign out_done             = done_q;
    assign out_clause_index     = idx_q;
    assign out_clause_satisfied = sat_q;
endmodule

// File: tb/tb_unsat_clause_scan_scheduler.sv
// tb_unsat_clause_scan_scheduler: N=16 and N=12 instances driven in parallel, checked against a clause-list search model.
module tb_unsat_clause_scan_scheduler;
    logic        clk = 1'b0;
    logic        rst, start, seed_ld;
    logic [15:0] clauses, seed;
    logic        busy16, done16, sat16, busy12, done12, sat12;
    logic [3:0]  idx16, idx12;
    logic [15:0] m_lfsr;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    unsat_clause_scan_scheduler #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(4), .NUMBER_OF_CLAUSES(16), .LFSR_WIDTH(16)) u16 (
        .in_clk(clk), .in_reset(rst), .in_start(start), .in_clauses_satisfied(clauses),
        .in_seed_load(seed_ld), .in_seed(seed), .out_busy(busy16), .out_done(done16),
        .out_clause_index(idx16), .out_clause_satisfied(sat16));

    unsat_clause_scan_scheduler #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(4), .NUMBER_OF_CLAUSES(12), .LFSR_WIDTH(16)) u12 (
        .in_clk(clk), .in_reset(rst), .in_start(start), .in_clauses_satisfied(clauses[11:0]),
        .in_seed_load(seed_ld), .in_seed(seed), .out_busy(busy12), .out_done(done12),
        .out_clause_index(idx12), .out_clause_satisfied(sat12));

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Walk the clause list from the random start (modulo n); the first unsatisfied clause wins
    task automatic model(input logic [15:0] snap, input int n, input logic [15:0] l,
                         output int idx, output int sat, output int k);
        int s;
        s = int'(l[3:0]);
        if (s >= n) s -= n;
        idx = 0; sat = 1; k = n;
        for (int i = 0; i < n; i++) begin
            int p;
            p = (s + i) % n;
            if (!snap[p]) begin
                idx = p; sat = 0; k = i + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic load_seed(input logic [15:0] sd);
        @(negedge clk);
        seed_ld = 1'b1; seed = sd;
        @(posedge clk);
        #1;
        seed_ld = 1'b0;
        m_lfsr = (sd == 16'h0) ? 16'h1 : sd;
    endtask

    task automatic scan(input logic [15:0] snap, input logic ld, input logic [15:0] sd, input bit disturb);
        int ei16, es16, k16, ei12, es12, k12, at16, at12, nd16, nd12;
        model(snap, 16, m_lfsr, ei16, es16, k16);
        model(snap, 12, m_lfsr, ei12, es12, k12);
        m_lfsr = ld ? ((sd == 16'h0) ? 16'h1 : sd) : adv(m_lfsr);
        @(negedge clk);
        start = 1'b1; clauses = snap; seed_ld = ld; seed = sd;
        @(posedge clk);
        #1;
        start = 1'b0; seed_ld = 1'b0;
        chk("busy16_first", int'(busy16), 1);
        chk("busy12_first", int'(busy12), 1);
        if (disturb) begin
            start = 1'b1; seed_ld = 1'b1; seed = 16'($urandom); clauses = ~snap;
        end
        at16 = 0; at12 = 0; nd16 = 0; nd12 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                start = 1'b0; seed_ld = 1'b0;
            end
            if (done16) begin nd16++; if (at16 == 0) at16 = c; end
            if (done12) begin nd12++; if (at12 == 0) at12 = c; end
            if (c < k16) chk("busy16_scan", int'(busy16), 1);
            if (c < k12) chk("busy12_scan", int'(busy12), 1);
        end
        chk("done16_latency", at16, k16);
        chk("done12_latency", at12, k12);
        chk("done16_pulses", nd16, 1);
        chk("done12_pulses", nd12, 1);
        chk("index16", int'(idx16), ei16);
        chk("index12", int'(idx12), ei12);
        chk("allsat16", int'(sat16), es16);
        chk("allsat12", int'(sat12), es12);
        chk("idle16", int'({busy16, done16}), 0);
        chk("idle12", int'({busy12, done12}), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; seed_ld = 1'b0; clauses = '0; seed = '0;
        do_reset();
        chk("reset16", int'({busy16, done16, sat16, idx16}), 0);
        chk("reset12", int'({busy12, done12, sat12, idx12}), 0);
        scan(16'hFFDF, 1'b0, 16'h0, 1'b0);
        do_reset();
        scan(16'hFFFE, 1'b0, 16'h0, 1'b0);
        do_reset();
        scan(16'hFFFF, 1'b0, 16'h0, 1'b0);
        scan(16'hFFFF, 1'b0, 16'h0, 1'b0);
        load_seed(16'h000E);
        scan(16'hFFFB, 1'b0, 16'h0, 1'b0);
        load_seed(16'h0000);
        scan(16'hFF7F, 1'b0, 16'h0, 1'b0);
        scan(16'hF7FF, 1'b0, 16'h0, 1'b1);
        scan(16'h7FFF, 1'b1, 16'h1234, 1'b0);
        scan(16'hFFFF, 1'b0, 16'h0, 1'b0);
        // Abort a long scan with reset sampled on the edge ending its third SCAN cycle
        @(negedge clk);
        start = 1'b1; clauses = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        chk("abort16", int'({busy16, done16, sat16, idx16}), 0);
        chk("abort12", int'({busy12, done12, sat12, idx12}), 0);
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("abort_nodone", int'({done16, done12}), 0);
        end
        scan(16'hFFDF, 1'b0, 16'h0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            logic [15:0] s;
            s = (t % 5 == 0) ? 16'hFFFF : 16'($urandom | $urandom | $urandom);
            scan(s, ($urandom_range(3) == 0), 16'($urandom_range(3) == 0 ? 0 : $urandom), ($urandom_range(1) == 1));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/unsat_clause_scan_scheduler.md
Name: unsat_clause_scan_scheduler

Overview:
- Sequential selector for the stochastic-search step: from a clause-satisfaction vector, picks one unsatisfied clause at a pseudo-random position.
- Replaces the wide combinational compare-two tree with a one-clause-per-cycle scan.
- Scan starts at an LFSR-derived index and wraps around the clause list.
- Feeds the chosen clause index to the variable-flip stage; also reports when every clause is satisfied, i.e. a solution has been found.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 4, width of a clause index.
- NUMBER_OF_CLAUSES, 16, clauses scanned. Legal range: 2^(W-1) < N <= 2^W.
- LFSR_WIDTH, 16, width of the random-start LFSR. Must be >= W.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  request a selection; sampled only in IDLE.
- in_clauses_satisfied  input  NUMBER_OF_CLAUSES  bit i = 1 means clause i is satisfied; snapshotted on start.
- in_seed_load  input  1  load in_seed into the LFSR; honoured only in IDLE.
- in_seed  input  LFSR_WIDTH  seed value.
- out_busy  output  1  scan in progress.
- out_done  output  1  one-cycle pulse when the result is valid.
- out_clause_index  output  W  selected unsatisfied clause index.
- out_clause_satisfied  output  1  1 means no unsatisfied clause was found (all satisfied).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; LFSR = 16'hACE1 (low LFSR_WIDTH bits if narrower).
  - out_busy = 0, out_done = 0, out_clause_index = 0, out_clause_satisfied = 0.
  - Snapshot, pointer and counter = 0.
  - Reset asserted mid-scan aborts the scan: no out_done, outputs return to reset values.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1 (taps 16,14,13,11); shift left, feedback into bit 0.
  - Advances exactly once per accepted start.
  - in_seed_load in IDLE: LFSR <= in_seed; an all-zero seed is replaced by 1.
  - If seed_load and start coincide: the start uses the pre-load LFSR value; the LFSR takes the seed (the load overrides the advance).
- Start index:
  - r = LFSR[W-1:0]; start = r if r < N, else r - N.
  - Always lands in [0, N-1] given the parameter constraint; no divider is needed.
- FSM states: IDLE, SCAN, DONE.
  - IDLE, in_start=1 at edge E0:
    - Snapshot <= in_clauses_satisfied; pointer <= start; count <= 0.
    - out_busy <= 1; out_done <= 0; state <= SCAN.
  - SCAN, each edge, examines snapshot[pointer]:
    - Bit = 0: out_clause_index <= pointer; out_clause_satisfied <= 0; state <= DONE.
    - Bit = 1 and count == N-1: out_clause_index <= 0; out_clause_satisfied <= 1; state <= DONE.
    - Otherwise: pointer <= (pointer == N-1) ? 0 : pointer+1; count <= count+1.
  - DONE, one cycle: out_done = 1 (registered), out_busy <= 0; next edge state <= IDLE, out_done <= 0.
- Latency:
  - k = number of clauses examined, 1..N.
  - The SCAN result is registered at edge E0+k; out_done is high during the cycle following that edge.
  - Minimum is 1 SCAN cycle; maximum is N cycles plus the DONE cycle.
- Ignored inputs:
  - in_start and in_seed_load are ignored while out_busy = 1 or in DONE.
  - Changes to in_clauses_satisfied during a scan do not affect the result (snapshot).
- out_clause_index and out_clause_satisfied hold their values from DONE until the next accepted start; a new start does not clear them until its own DONE.
- Pointer wrap: N-1 -> 0, including when N < 2^W (index N is never visited).

Test Plan:
1. Reset, N=16, LFSR=ACE1 (start=1). Snapshot 16'hFFDF (clause 5 unsatisfied), pulse start -> clauses 1..5 scanned, out_done 5 edges after the scan's first edge, out_clause_index=5, out_clause_satisfied=0, out_busy high throughout.
2. Wrap-around: snapshot 16'hFFFE, start=1 -> scans 1..15 then 0; out_clause_index=0, out_clause_satisfied=0, 16 SCAN cycles.
3. All satisfied: snapshot 16'hFFFF -> 16 SCAN cycles, out_clause_satisfied=1, out_clause_index=0; second start uses the advanced LFSR (start=ACE1<<1|fb low bits).
4. Seeding, with N=12, W=4:
   - in_seed_load with seed 16'h000E, then start with snapshot 12'hFFB -> start=14-12=2, result index 2 after 1 SCAN cycle.
   - Seed 0 -> LFSR=1, start=1.
5. Busy protection: during a scan, pulse in_start and toggle in_clauses_satisfied -> no restart, result matches the original snapshot, exactly one out_done.
6. Reset mid-scan: assert in_reset on the 3rd SCAN cycle -> next edge all outputs 0, no out_done, LFSR=ACE1; a subsequent start behaves as in scenario 1.
